// File: rtl/enc_seq_pkg.sv
// enc_seq_pkg: shared state type and latency-counter sizing for the encoder sequencer
package enc_seq_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, CAPT, WRITE, NEXT, DONE} state_t;
  localparam int RD_LAT_MAX = 8;
  localparam int LAT_W = $clog2(RD_LAT_MAX);
endpackage

// File: rtl/enc_word_counter.sv
// enc_word_counter: word index with clear/advance and a flag on the final word of a pass
module enc_word_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W:0]   len_q,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);
  always_ff @(posedge clk) begin
    if (!rst) idx <= '0;
    else if (clr) idx <= '0;
    else if (en) idx <= idx + 1'b1;
  end
  assign last = {1'b0, idx} == len_q - 1'b1;
endmodule

// File: rtl/enc_seq_ctrl.sv
// enc_seq_ctrl: read/capture/write word sequencer with run-time length, loop mode and abort
module enc_seq_ctrl
  import enc_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              inreg_en,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(RD_LAT - 2);
  state_t state, nxt;
  logic [ADDR_W:0] len_q;
  logic loop_q, aborted_q, clr, inc, last;
  logic [LAT_W-1:0] lat;
  logic [ADDR_W-1:0] idx;
  enc_word_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(inc), .len_q(len_q), .idx(idx), .last(last)
  );
  always_comb begin
    nxt = state;
    clr = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE: begin
        nxt = start ? ((len == '0) ? DONE : READ) : IDLE;
        clr = start && (len != '0);
      end
      READ:  nxt = (RD_LAT == 1) ? CAPT : WAIT;
      WAIT:  nxt = (lat == LAT_END) ? CAPT : WAIT;
      CAPT:  nxt = WRITE;
      WRITE: nxt = wr_ready ? NEXT : WRITE;
      NEXT: begin
        nxt = last ? DONE : READ;
        inc = !last;
      end
      DONE: begin
        nxt = loop_q ? READ : IDLE;
        clr = loop_q;
      end
      default: nxt = IDLE;
    endcase
    // abort wins over every transition, including a write accepted this cycle
    if (abort && state != IDLE) begin
      nxt = IDLE;
      clr = 1'b0;
      inc = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      loop_q    <= 1'b0;
      lat       <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= nxt;
      aborted_q <= abort && state != IDLE;
      lat       <= (state == WAIT) ? lat + 1'b1 : '0;
      if (state == IDLE && start && len != '0) begin
        len_q  <= (len > LEN_MAX) ? LEN_MAX : len;
        loop_q <= loop;
      end
    end
  end
  assign busy     = state != IDLE;
  assign addr     = busy ? idx : '0;
  assign rd_en    = state == READ;
  assign inreg_en = state == CAPT;
  assign wr_en    = state == WRITE;
  assign done     = state == DONE;
  assign aborted  = aborted_q;
endmodule

// File: tb/tb_enc_seq_ctrl.sv
// tb_enc_seq_ctrl: two sequencers (read latency 1 and 3) on shared stimulus, checked against a word/offset model
module tb_enc_seq_ctrl;
  localparam int AW = 6;
  logic clk = 0, rst = 0, start = 0, loop = 0, abort = 0, wr_ready = 1;
  logic [AW:0] len = '0;
  logic [AW-1:0] addr1, addr3;
  logic rd1, inr1, wr1, busy1, done1, ab1, rd3, inr3, wr3, busy3, done3, ab3;
  logic [11:0] o[2];
  always #5 clk = ~clk;
  enc_seq_ctrl #(.ADDR_W(AW), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .len(len), .abort(abort), .wr_ready(wr_ready),
    .addr(addr1), .rd_en(rd1), .inreg_en(inr1), .wr_en(wr1), .busy(busy1), .done(done1), .aborted(ab1)
  );
  enc_seq_ctrl #(.ADDR_W(AW), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .len(len), .abort(abort), .wr_ready(wr_ready),
    .addr(addr3), .rd_en(rd3), .inreg_en(inr3), .wr_en(wr3), .busy(busy3), .done(done3), .aborted(ab3)
  );
  assign o[0] = {addr1, rd1, inr1, wr1, busy1, done1, ab1};
  assign o[1] = {addr3, rd3, inr3, wr3, busy3, done3, ab3};
  // model: mode 0 idle, 1 moving a word (off = cycles into that word), 2 pass complete
  int mode[2], off[2], idx[2], lenq[2];
  bit loopq[2], ab[2];
  function automatic int lt(int k);
    return k ? 3 : 1;
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mode[k] = 0; off[k] = 0; idx[k] = 0; lenq[k] = 0; loopq[k] = 0; ab[k] = 0;
      end else if (mode[k] != 0 && abort) begin
        mode[k] = 0; ab[k] = 1;
      end else begin
        ab[k] = 0;
        if (mode[k] == 0) begin
          if (start && len == 0) mode[k] = 2;
          else if (start) begin
            lenq[k] = (int'(len) > 64) ? 64 : int'(len);
            loopq[k] = loop; idx[k] = 0; off[k] = 0; mode[k] = 1;
          end
        end else if (mode[k] == 2) begin
          if (loopq[k]) begin mode[k] = 1; idx[k] = 0; off[k] = 0; end
          else mode[k] = 0;
        end else if (off[k] == lt(k) + 1) begin
          if (wr_ready) off[k]++;
        end else if (off[k] == lt(k) + 2) begin
          if (idx[k] == lenq[k] - 1) mode[k] = 2;
          else begin idx[k]++; off[k] = 0; end
        end else off[k]++;
      end
    end
  end
  function automatic logic [11:0] exp_out(int k);
    logic w = mode[k] == 1;
    return {mode[k] != 0 ? 6'(idx[k]) : 6'd0, w && off[k] == 0, w && off[k] == lt(k),
            w && off[k] == lt(k) + 1, mode[k] != 0, mode[k] == 2, ab[k]};
  endfunction
  int checks = 0, errors = 0, cyc = 0;
  bit en = 0;
  int rd_cnt[2], wr_cnt[2], done_cnt[2], done_at[2], ab_cnt[2], last_rd[2];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", n, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (en) chk(k ? "lock_L3" : "lock_L1", int'(o[k]), int'(exp_out(k)));
      rd_cnt[k] += int'(o[k][5]);
      wr_cnt[k] += int'(o[k][3]);
      done_cnt[k] += int'(o[k][1]);
      ab_cnt[k] += int'(o[k][0]);
      if (o[k][5]) last_rd[k] = int'(o[k][11:6]);
      if (o[k][1]) done_at[k] = cyc;
    end
  endtask
  task automatic go(input int l, input bit lp, output int c);
    len = 7'(l); loop = lp; start = 1; c = cyc;
    tick();
    start = 0;
  endtask
  task automatic wait_dones(input int n0, input int n1);
    for (int i = 0; i < 1000 && (done_cnt[0] < n0 || done_cnt[1] < n1); i++) tick();
    chk("wait_done", int'(done_cnt[0] >= n0 && done_cnt[1] >= n1), 1);
  endtask
  task automatic wait_wr(input int k, input int a);
    for (int i = 0; i < 100 && !(o[k][3] && int'(o[k][11:6]) == a); i++) tick();
    chk("wait_wr", int'(o[k][3] && int'(o[k][11:6]) == a), 1);
  endtask
  typedef struct {int len; int cyc1; int cyc3; int rds; int last;} vec_t;
  vec_t tbl[5];
  initial begin
    int c, d[2], b[2];
    tbl[0] = '{4, 18, 26, 4, 3};
    tbl[1] = '{2, 10, 14, 2, 1};
    tbl[2] = '{0, 2, 2, 0, -1};
    tbl[3] = '{1, 6, 8, 1, 0};
    tbl[4] = '{69, 258, 386, 64, 63};
    tick(); tick();
    en = 1;
    chk("reset_L1", int'(o[0]), 0);
    chk("reset_L3", int'(o[1]), 0);
    rst = 1;
    tick();
    go(4, 0, c);
    wait_wr(1, 0);
    rst = 0;
    tick();
    chk("midrst_L1", int'(o[0]), 0);
    chk("midrst_L3", int'(o[1]), 0);
    rst = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      d = done_cnt; b = rd_cnt; last_rd = '{-1, -1};
      go(tbl[i].len, 0, c);
      wait_dones(d[0] + 1, d[1] + 1);
      chk("tbl_cyc_L1", done_at[0] - c + 1, tbl[i].cyc1);
      chk("tbl_cyc_L3", done_at[1] - c + 1, tbl[i].cyc3);
      chk("tbl_rds_L1", rd_cnt[0] - b[0], tbl[i].rds);
      chk("tbl_rds_L3", rd_cnt[1] - b[1], tbl[i].rds);
      chk("tbl_last_L1", last_rd[0], tbl[i].last);
      chk("tbl_last_L3", last_rd[1], tbl[i].last);
      tick(); tick();
    end
    d = done_cnt; b = wr_cnt;
    go(4, 0, c);
    wait_wr(0, 1);
    wr_ready = 0;
    repeat (5) tick();
    wr_ready = 1;
    wait_dones(d[0] + 1, d[1] + 1);
    chk("bp_cyc_L1", done_at[0] - c + 1, 23);
    chk("bp_wr_L1", wr_cnt[0] - b[0], 9);
    tick(); tick();
    d = done_cnt;
    go(4, 0, c);
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abw_busy", int'({o[0][2], o[1][2]}), 0);
    chk("abw_pulse", int'({o[0][0], o[1][0]}), 3);
    b = rd_cnt; c = ab_cnt[0] + ab_cnt[1];
    repeat (10) tick();
    chk("abw_rd", rd_cnt[0] - b[0] + rd_cnt[1] - b[1], 0);
    chk("abw_once", ab_cnt[0] + ab_cnt[1] - c, 0);
    chk("abw_done", done_cnt[0] - d[0] + done_cnt[1] - d[1], 0);
    d = done_cnt;
    go(4, 0, c);
    wait_wr(0, 0);
    abort = 1;
    tick();
    abort = 0;
    chk("abr_wr", int'(o[0][3]), 0);
    chk("abr_state", int'({o[0][2], o[0][0], o[1][2], o[1][0]}), 5);
    repeat (10) tick();
    chk("abr_done", done_cnt[0] - d[0] + done_cnt[1] - d[1], 0);
    d = done_cnt; b = rd_cnt;
    go(3, 1, c);
    repeat (3) tick();
    start = 1; len = 7'd1; loop = 0;
    tick();
    start = 0;
    wait_dones(d[0] + 1, 0);
    chk("loop_first", done_at[0] - c + 1, 14);
    wait_dones(d[0] + 3, 0);
    chk("loop_d3", done_cnt[1] - d[1], 2);
    chk("loop_rd", rd_cnt[0] - b[0], 9);
    abort = 1;
    tick();
    abort = 0;
    chk("loop_abort", int'({o[0][2], o[1][2]}), 0);
    d = done_cnt;
    repeat (20) tick();
    chk("loop_stop", done_cnt[0] - d[0] + done_cnt[1] - d[1], 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      rst = $urandom_range(0, 199) != 0;
      start = $urandom_range(0, 9) == 0;
      len = (r == 0) ? 7'd0 : (r == 1) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(1, 6));
      loop = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 49) == 0;
      wr_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 1; start = 0; abort = 0; wr_ready = 1;
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
